// File: rtl/cpu_pad_pkg.sv
// Shared types and defaults for the CPU opponent pad and its tick/LFSR helper.
package cpu_pad_pkg;

    // Decision FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_JUMP,
        ST_ATTACK,
        ST_SHIELD,
        ST_GAP
    } pad_state_t;

    // Taps of x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form (bits 0,2,3,5)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [9:0] DEF_ATTACK_RANGE = 10'd64;
    localparam logic [9:0] DEF_FAR_RANGE    = 10'd160;
    localparam int         DEF_PRESS_TICKS  = 4;
    localparam int         DEF_GAP_TICKS    = 2;
    localparam int         DEF_SHIELD_TICKS = 12;

    // Wide enough for any hold duration the pad uses
    localparam int HOLD_W = 8;

    // One Fibonacci step: feedback enters at bit 15, register shifts right
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    // Unsigned distance between two positions, never wraps
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tick_lfsr.sv
// Decision-tick divider plus a 16-bit LFSR that advances once per tick.
// Reusable wherever game logic needs a slow strobe and cheap randomness.
module tick_lfsr
    import cpu_pad_pkg::*;
#(
    parameter int          TICK_MAX  = 714_285,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_l,
    output logic        tick,
    output logic [15:0] lfsr
);

    localparam int                CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_MAX - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_LAST);

    // Free-running divider: 0..TICK_MAX-1, tick on the last count
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l)    count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 1'b1;
    end

    // LFSR shifts on tick; an all-zero register (lock-up state) reloads the seed
    always_ff @(posedge clk) begin
        if (!rst_l)              lfsr <= LFSR_SEED;
        else if (lfsr == 16'h0)  lfsr <= LFSR_SEED;
        else if (tick)           lfsr <= lfsr_next(lfsr);
    end

endmodule

// File: rtl/cpu_opponent_pad.sv
// Computer-driven joystick for single-player mode. Emits the same pin-level
// signals as a human pad; every press is held a whole number of decision
// ticks and followed by a released gap so the controller's debounce sees it.
module cpu_opponent_pad
    import cpu_pad_pkg::*;
#(
    parameter int          TICK_MAX     = 714_285,
    parameter logic [9:0]  ATTACK_RANGE = DEF_ATTACK_RANGE,
    parameter logic [9:0]  FAR_RANGE    = DEF_FAR_RANGE,
    parameter int          PRESS_TICKS  = DEF_PRESS_TICKS,
    parameter int          GAP_TICKS    = DEF_GAP_TICKS,
    parameter int          SHIELD_TICKS = DEF_SHIELD_TICKS,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       enable,
    input  logic [1:0] finish,
    input  logic [9:0] self_x,
    input  logic [9:0] opp_x,
    input  logic       opp_attack_grant,
    output logic       left_l,
    output logic       right_l,
    output logic       up_l,
    output logic       down_l,
    output logic       attack,
    output logic       shield
);

    logic        tick;
    logic [15:0] lfsr;
    logic        lfsr_unused;

    tick_lfsr #(
        .TICK_MAX (TICK_MAX),
        .LFSR_SEED(LFSR_SEED)
    ) u_tick_lfsr (
        .clk  (clk),
        .rst_l(rst_l),
        .tick (tick),
        .lfsr (lfsr)
    );

    // Only the low nibble feeds decisions
    assign lfsr_unused = ^lfsr[15:4];

    logic [9:0] dx;
    logic       toward_right;
    logic       override;

    assign dx           = abs_diff(self_x, opp_x);
    assign toward_right = (opp_x > self_x);
    assign override     = !enable || (finish != 2'b00);

    pad_state_t        state;
    logic [HOLD_W-1:0] hold;

    // Active-low {left_l, right_l} for a move in the given direction
    function automatic logic [1:0] dir_pins(input logic go_right);
        return go_right ? 2'b10 : 2'b01;
    endfunction

    // Decision FSM: all state and pin changes land on tick edges, except the
    // override which releases the pad on the very next clock
    always_ff @(posedge clk) begin
        if (!rst_l || override) begin
            state   <= ST_IDLE;
            hold    <= '0;
            left_l  <= 1'b1;
            right_l <= 1'b1;
            up_l    <= 1'b1;
            down_l  <= 1'b1;
            attack  <= 1'b0;
            shield  <= 1'b0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    hold <= HOLD_W'(PRESS_TICKS);
                    if (opp_attack_grant && (dx <= ATTACK_RANGE) && (lfsr[1:0] != 2'b00)) begin
                        state  <= ST_SHIELD;
                        hold   <= HOLD_W'(SHIELD_TICKS);
                        shield <= 1'b1;
                    end else if (dx <= ATTACK_RANGE) begin
                        state  <= ST_ATTACK;
                        attack <= 1'b1;
                    end else if (dx > FAR_RANGE) begin
                        state             <= ST_MOVE;
                        {left_l, right_l} <= dir_pins(toward_right);
                    end else begin
                        case (lfsr[3:2])
                            2'b00: begin
                                state <= ST_JUMP;
                                up_l  <= 1'b0;
                            end
                            2'b01: begin
                                state             <= ST_MOVE;
                                {left_l, right_l} <= dir_pins(!toward_right);
                            end
                            default: begin
                                state             <= ST_MOVE;
                                {left_l, right_l} <= dir_pins(toward_right);
                            end
                        endcase
                    end
                end
                ST_MOVE, ST_JUMP, ST_ATTACK, ST_SHIELD: begin
                    if (hold == HOLD_W'(1)) begin
                        state   <= ST_GAP;
                        hold    <= HOLD_W'(GAP_TICKS);
                        left_l  <= 1'b1;
                        right_l <= 1'b1;
                        up_l    <= 1'b1;
                        attack  <= 1'b0;
                        shield  <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                ST_GAP: begin
                    // IDLE decides on the tick after this one, so the released
                    // stretch spans GAP_TICKS plus that decision tick
                    if (hold == HOLD_W'(1)) state <= ST_IDLE;
                    hold <= hold - 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    hold  <= '0;
                end
            endcase
        end
    end

endmodule
